// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Counts spikes per output neuron over a programmable window of enabled
//   (execute) cycles. It then scans the counters sequentially to find the
//   most active neuron and presents the result on a valid/ready handshake.
//
//   Optional feature macro: SPIKE_DECODER_AUTORESTART_EN
//     defined   : an accepted result restarts accumulation immediately,
//                 clearing the counters and reusing the latched window.
//     undefined : an accepted result returns to IDLE, so every window
//                 needs its own start pulse.
//
// Ports
//   clk          : clock
//   reset        : asynchronous, active-high reset
//   enable       : network execute strobe; spikes are sampled only when high
//   spikes       : per-neuron spike vector from the output layer
//   window       : window length in enabled cycles (0 = 2^WINDOW_BITS),
//                  latched on start
//   start        : begin a measurement (honoured only in IDLE)
//   busy         : high whenever the block is not IDLE
//   out_valid    : result available (HOLD state)
//   out_ready    : consumer accepts the result
//   winner       : index of the neuron with the highest count
//   winner_count : count of the winner
//   tie          : another neuron has a count equal to winner_count
module spike_rate_decoder #(
  parameter int NEURONS     = 8,
  parameter int COUNT_BITS  = 8,
  parameter int WINDOW_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NEURONS-1:0]         spikes,
  input  logic [WINDOW_BITS-1:0]     window,
  input  logic                       start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NEURONS)-1:0] winner,
  output logic [COUNT_BITS-1:0]      winner_count,
  output logic                       tie
);

  localparam int IDX_W  = $clog2(NEURONS);
  // The scan index runs one step past the last neuron as a finalize cycle.
  localparam int SCAN_W = $clog2(NEURONS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [COUNT_BITS-1:0]  cnt [NEURONS];
  logic [WINDOW_BITS:0]   win_len;
  logic [WINDOW_BITS:0]   win_cnt;
  logic [SCAN_W-1:0]      scan_idx;
  logic [COUNT_BITS-1:0]  scan_cnt;
  logic                   last_sample;
  logic                   scan_done;
  logic                   xfer;
  logic                   clear_acc;

  function automatic logic [COUNT_BITS-1:0] sat_inc(
    input logic [COUNT_BITS-1:0] c,
    input logic                  inc
  );
    if (inc && (c != {COUNT_BITS{1'b1}})) return c + 1'b1;
    return c;
  endfunction

  assign last_sample = (state == ACCUM) && enable && (win_cnt == (win_len - 1'b1));
  assign scan_done   = (scan_idx == SCAN_W'(NEURONS));
  assign xfer        = out_valid && out_ready;
  assign scan_cnt    = cnt[scan_idx[IDX_W-1:0]];

`ifdef SPIKE_DECODER_AUTORESTART_EN
  assign clear_acc = ((state == IDLE) && start) || xfer;
`else
  assign clear_acc = (state == IDLE) && start;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: if (last_sample) state_nxt = SCAN;
      SCAN:  if (scan_done) state_nxt = HOLD;
      HOLD: begin
`ifdef SPIKE_DECODER_AUTORESTART_EN
        if (xfer) state_nxt = ACCUM;
`else
        if (xfer) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == HOLD);
  end

  // Accumulation stage: window bookkeeping and per-neuron saturating counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_len <= '0;
      win_cnt <= '0;
      for (int i = 0; i < NEURONS; i++) cnt[i] <= '0;
    end else begin
      if ((state == IDLE) && start)
        win_len <= (window == '0) ? {1'b1, {WINDOW_BITS{1'b0}}} : {1'b0, window};
      if (clear_acc) begin
        win_cnt <= '0;
        for (int i = 0; i < NEURONS; i++) cnt[i] <= '0;
      end else if ((state == ACCUM) && enable) begin
        win_cnt <= win_cnt + 1'b1;
        for (int i = 0; i < NEURONS; i++) cnt[i] <= sat_inc(cnt[i], spikes[i]);
      end
    end
  end

  // Scan stage: one neuron per cycle, lowest index kept on equal counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx     <= '0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (!scan_done) begin
        if (scan_idx == '0) begin
          winner       <= '0;
          winner_count <= scan_cnt;
          tie          <= 1'b0;
        end else if (scan_cnt > winner_count) begin
          winner       <= scan_idx[IDX_W-1:0];
          winner_count <= scan_cnt;
          tie          <= 1'b0;
        end else if (scan_cnt == winner_count) begin
          tie          <= 1'b1;
        end
      end
    end else begin
      scan_idx <= '0;
    end
  end

endmodule
